// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
//   Requester 0 is the main datapath, requester 1 the address/branch unit.
//   Requests are arbitrated round-robin in IDLE. The winner's opcode and operands
//   are latched into the alu_* registers. The alu output is captured one cycle later
//   and returned with a one-cycle done pulse. Sequence: IDLE -> EXEC -> DONE -> IDLE.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   req0/1, op0/1, a0/1, b0/1
//                          request plus opcode/operands from requester 0/1
//   gnt0/1                 one-cycle pulse: request accepted, operands latched
//   done0/1                one-cycle pulse: res/res_cout valid for that requester
//   res, res_cout          registered alu result and carry/borrow
//   busy                   high whenever the FSM is not in IDLE
//   alu_rega/regb/control  latched operands/opcode driven to the alu
//   alu_out, alu_cout      combinational result back from the alu
module alu_arbiter #(
    parameter int unsigned DATA_WITH = 16,
    parameter int unsigned OP_SIZE   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [OP_SIZE-1:0]   op0,
    input  logic [OP_SIZE-1:0]   op1,
    input  logic [DATA_WITH-1:0] a0,
    input  logic [DATA_WITH-1:0] a1,
    input  logic [DATA_WITH-1:0] b0,
    input  logic [DATA_WITH-1:0] b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [DATA_WITH-1:0] res,
    output logic                 res_cout,
    output logic                 busy,
    output logic [DATA_WITH-1:0] alu_rega,
    output logic [DATA_WITH-1:0] alu_regb,
    output logic [OP_SIZE-1:0]   alu_control,
    input  logic [DATA_WITH-1:0] alu_out,
    input  logic                 alu_cout
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e               state_q, state_d;
    // Requester that wins a tie; after every grant it moves to the other requester.
    logic                 prio_q, prio_d;
    // Requester owning the operation in flight.
    logic                 win_q, win_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic [DATA_WITH-1:0] res_q, res_d;
    logic                 cout_q, cout_d;
    logic [DATA_WITH-1:0] rega_q, rega_d, regb_q, regb_d;
    logic [OP_SIZE-1:0]   ctrl_q, ctrl_d;
    logic                 pick1;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win_d   = win_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res_d   = res_q;
        cout_d  = cout_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        ctrl_d  = ctrl_q;
        pick1   = req1 & (~req0 | prio_q);

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    win_d   = pick1;
                    prio_d  = ~pick1;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    rega_d  = pick1 ? a1  : a0;
                    regb_d  = pick1 ? b1  : b0;
                    ctrl_d  = pick1 ? op1 : op0;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d   = alu_out;
                cout_d  = alu_cout;
                done0_d = ~win_q;
                done1_d = win_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            rega_q  <= '0;
            regb_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign res         = res_q;
    assign res_cout    = cout_q;
    assign busy        = (state_q != StIdle);
    assign alu_rega    = rega_q;
    assign alu_regb    = regb_q;
    assign alu_control = ctrl_q;

endmodule
